// File: rtl/imem_loader_if.sv
// Host-side bus of the instruction-memory loader: session control, byte
// stream, memory word port and pipeline control.
interface imem_loader_if;
    logic        start;
    logic [6:0]  word_count;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        pc_enable;
    logic        if_id_enable;
    logic        pipeline_reset;
    logic        busy;
    logic        done;
    logic        load_error;

    modport slave (
        input  start, word_count, abort, byte_valid, byte_in,
        output byte_ready, mem_write_enable, mem_address, mem_data,
               pc_enable, if_id_enable, pipeline_reset, busy, done, load_error
    );

    modport master (
        output start, word_count, abort, byte_valid, byte_in,
        input  byte_ready, mem_write_enable, mem_address, mem_data,
               pc_enable, if_id_enable, pipeline_reset, busy, done, load_error
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them to instruction
// memory and holds the CPU pipeline in reset until the load session finishes.
module imem_loader #(
    parameter int RESET_HOLD = 2,
    parameter int MAX_WORDS  = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RELEASE, DONE} state_t;

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [6:0]    MAX_CNT   = 7'(MAX_WORDS);

    state_t        state_q, state_d;
    logic [6:0]    count_q, count_d;
    logic [6:0]    word_index_q, word_index_d;
    logic [1:0]    byte_index_q, byte_index_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   word_q, word_d;
    logic          load_error_q, load_error_d;
    logic [7:0]    mem_address_q, mem_address_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          byte_ready_q, mem_write_enable_q, busy_q, done_q;
    logic          pc_enable_q, if_id_enable_q, pipeline_reset_q;
    logic [6:0]    clamped_count;

    assign clamped_count = (bus.word_count > MAX_CNT) ? MAX_CNT : bus.word_count;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        word_index_d  = word_index_q;
        byte_index_d  = byte_index_q;
        hold_d        = hold_q;
        word_d        = word_q;
        load_error_d  = load_error_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d      = clamped_count;
                    word_index_d = '0;
                    byte_index_d = '0;
                    hold_d       = '0;
                    load_error_d = 1'b0;
                    state_d      = (clamped_count == 7'd0) ? RELEASE : LOAD;
                end
            end
            LOAD: begin
                // Abort outranks a byte arriving on the same edge; that byte is dropped.
                if (bus.abort) begin
                    load_error_d = 1'b1;
                    byte_index_d = '0;
                    hold_d       = '0;
                    state_d      = RELEASE;
                end else if (bus.byte_valid) begin
                    word_d = {word_q[23:0], bus.byte_in};
                    if (byte_index_q == 2'd3) begin
                        byte_index_d  = '0;
                        mem_data_d    = {word_q[23:0], bus.byte_in};
                        mem_address_d = 8'({word_index_q, 2'b00});
                        state_d       = WRITE;
                    end else begin
                        byte_index_d = byte_index_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                word_index_d = word_index_q + 7'd1;
                hold_d       = '0;
                if (bus.abort) begin
                    load_error_d = 1'b1;
                    state_d      = RELEASE;
                end else if (word_index_q + 7'd1 == count_q) begin
                    state_d = RELEASE;
                end else begin
                    state_d = LOAD;
                end
            end
            RELEASE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = DONE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            count_q            <= '0;
            word_index_q       <= '0;
            byte_index_q       <= '0;
            hold_q             <= '0;
            word_q             <= '0;
            load_error_q       <= 1'b0;
            mem_address_q      <= '0;
            mem_data_q         <= '0;
            byte_ready_q       <= 1'b0;
            mem_write_enable_q <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pc_enable_q        <= 1'b1;
            if_id_enable_q     <= 1'b1;
            pipeline_reset_q   <= 1'b0;
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            word_index_q       <= word_index_d;
            byte_index_q       <= byte_index_d;
            hold_q             <= hold_d;
            word_q             <= word_d;
            load_error_q       <= load_error_d;
            mem_address_q      <= mem_address_d;
            mem_data_q         <= mem_data_d;
            // Outputs are decoded from the next state so they are glitch-free registers.
            byte_ready_q       <= (state_d == LOAD);
            mem_write_enable_q <= (state_d == WRITE);
            busy_q             <= (state_d != IDLE);
            done_q             <= (state_d == DONE) && !load_error_d;
            pc_enable_q        <= (state_d == IDLE);
            if_id_enable_q     <= (state_d == IDLE);
            pipeline_reset_q   <= (state_d != IDLE);
        end
    end

    assign bus.byte_ready       = byte_ready_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_data         = mem_data_q;
    assign bus.pc_enable        = pc_enable_q;
    assign bus.if_id_enable     = if_id_enable_q;
    assign bus.pipeline_reset   = pipeline_reset_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.load_error       = load_error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed sessions push expected writes and
// done pulses; a negedge monitor pops and compares them.
module tb_imem_loader;
    localparam int RESET_HOLD = 2;
    localparam int MAX_WORDS  = 64;

    logic clk = 1'b0;
    logic reset;
    imem_loader_if bus ();

    imem_loader #(.RESET_HOLD(RESET_HOLD), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobe and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("pipe ctl", {29'd0, bus.pc_enable, bus.if_id_enable, bus.pipeline_reset},
                  bus.busy ? 32'd1 : 32'd6);
            if (bus.mem_write_enable) begin
                wr_t e;
                wr_count++;
                check("ready in write", {31'd0, bus.byte_ready}, 32'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected write", 32'd1, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("write addr", {24'd0, bus.mem_address}, {24'd0, e.addr});
                    check("write data", bus.mem_data, e.data);
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) check("unexpected done", 32'd1, 32'd0);
                else void'(exp_done.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        bus.byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        forever begin
            @(negedge clk);
            if (bus.byte_ready) break;
            t++;
            if (t > 50) begin
                check("byte timeout", 32'd1, 32'd0);
                bus.byte_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic start_session(input logic [6:0] cnt);
        bus.start      = 1'b1;
        bus.word_count = cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle timeout", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    logic [31:0] t2_data [3] = '{32'hE0805183, 32'hE7D12000, 32'h1AFFFFFD};
    logic [31:0] w;

    initial begin
        int n;
        int base;
        reset = 1'b1;
        bus.start = 1'b0; bus.word_count = '0; bus.abort = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {24'd0, bus.byte_ready, bus.mem_write_enable, bus.pc_enable,
              bus.if_id_enable, bus.pipeline_reset, bus.busy, bus.done, bus.load_error},
              32'h30);
        check("reset addr", {24'd0, bus.mem_address}, 32'd0);
        check("reset data", bus.mem_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word, then measure done latency from the write cycle.
        push_wr(8'h00, 32'hE2010000);
        exp_done.push_back(1);
        start_session(7'd1);
        send_byte(8'hE2, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done || n > 20) break;
        end
        check("t1 done latency", n, RESET_HOLD + 2);
        wait_idle();

        // Three words with idle gaps between bytes.
        base = wr_count;
        for (int i = 0; i < 3; i++) push_wr(8'(i * 4), t2_data[i]);
        exp_done.push_back(1);
        start_session(7'd3);
        for (int i = 0; i < 3; i++) begin
            w = t2_data[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], (i + k) % 3);
        end
        wait_idle();
        check("t2 writes", wr_count - base, 3);

        // Clamp: 100 requested, 64 written, last at 0xFC.
        base = wr_count;
        for (int i = 0; i < 64; i++)
            push_wr(8'(i * 4), {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        exp_done.push_back(1);
        start_session(7'd100);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        for (int i = 0; i < RESET_HOLD + 2; i++) begin
            @(negedge clk);
            check("t3 ready after last", {31'd0, bus.byte_ready}, 32'd0);
        end
        wait_idle();
        check("t3 writes", wr_count - base, 64);
        check("t3 last addr", {24'd0, bus.mem_address}, 32'hFC);

        // Abort after one word plus two bytes, with a simultaneous byte.
        base = wr_count;
        push_wr(8'h00, 32'h11223344);
        start_session(7'd3);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        bus.abort = 1'b1; bus.byte_valid = 1'b1; bus.byte_in = 8'h77;
        @(posedge clk);
        #1;
        bus.abort = 1'b0; bus.byte_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!bus.busy || n > 20) break;
        end
        check("t4 busy cycles", n, RESET_HOLD + 2);
        check("t4 load_error", {31'd0, bus.load_error}, 32'd1);
        check("t4 writes", wr_count - base, 1);
        check("t4 data kept", bus.mem_data, 32'h11223344);
        @(posedge clk);
        #1;

        // Empty session: clears load_error, done after RESET_HOLD cycles.
        base = wr_count;
        exp_done.push_back(1);
        start_session(7'd0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) check("t5 error cleared", {31'd0, bus.load_error}, 32'd0);
            if (bus.done || n > 20) break;
        end
        check("t5 done latency", n, RESET_HOLD + 1);
        wait_idle();
        check("t5 writes", wr_count - base, 0);

        // Async reset mid-LOAD, between edges.
        base = wr_count;
        start_session(7'd2);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6 flags", {24'd0, bus.byte_ready, bus.mem_write_enable, bus.pc_enable,
              bus.if_id_enable, bus.pipeline_reset, bus.busy, bus.done, bus.load_error},
              32'h30);
        check("t6 addr", {24'd0, bus.mem_address}, 32'd0);
        check("t6 data", bus.mem_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.byte_in = 8'(i);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("t6 writes", wr_count - base, 0);
        check("t6 pc_enable", {31'd0, bus.pc_enable}, 32'd1);

        check("wr queue empty", exp_wr.size(), 0);
        check("done queue empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
